// File: rtl/pattern_detector_counter_if.sv
// Bus bundle for the serial pattern detector / BCD match counter.
// master drives stimulus and configuration, slave is the detector.
interface pattern_detector_counter_if #(
  parameter int MAX_LEN = 8,
  parameter int DIGITS  = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic                  ena;
  logic                  sig_to_test;
  logic                  cfg_valid;
  logic [MAX_LEN-1:0]    cfg_pattern;
  logic [LEN_W-1:0]      cfg_len;
  logic                  cfg_err;
  logic                  clr_count;
  logic                  z;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  sat;
  logic [7*DIGITS-1:0]   disp;

  modport master (
    output ena, sig_to_test, cfg_valid, cfg_pattern, cfg_len, clr_count,
    input  cfg_err, z, count_bcd, sat, disp
  );

  modport slave (
    input  ena, sig_to_test, cfg_valid, cfg_pattern, cfg_len, clr_count,
    output cfg_err, z, count_bcd, sat, disp
  );
endinterface

// File: rtl/pattern_detector_counter.sv
// Serial pattern detector with a loadable pattern of 1..MAX_LEN bits,
// a saturating BCD match counter and registered 7-segment digit drive.
module pattern_detector_counter #(
  parameter int MAX_LEN        = 8,
  parameter int DIGITS         = 2,
  parameter int OVERLAP        = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  pattern_detector_counter_if.slave   bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_CFG  = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Glyph for one BCD digit; codes outside 0..9 blank the digit.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0011000;
      default: g = 7'b1111111;
    endcase
    if (SEG_ACTIVE_LOW != 0) begin
      seg_glyph = g;
    end else begin
      seg_glyph = ~g;
    end
  endfunction

  // Segment image of a whole BCD count.
  function automatic logic [7*DIGITS-1:0] disp_of(input logic [4*DIGITS-1:0] c);
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = seg_glyph(c[4*i +: 4]);
    end
    disp_of = r;
  endfunction

  // Decimal increment with ripple carry across digits.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] c);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry && (c[4*i +: 4] == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (carry) begin
        r[4*i +: 4] = c[4*i +: 4] + 4'd1;
        carry       = 1'b0;
      end else begin
        r[4*i +: 4] = c[4*i +: 4];
      end
    end
    bcd_inc = r;
  endfunction

  // True when every digit reads 9 (the counter cannot advance further).
  function automatic logic all_nines(input logic [4*DIGITS-1:0] c);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c[4*i +: 4] != 4'd9) begin
        r = 1'b0;
      end else begin
        r = r;
      end
    end
    all_nines = r;
  endfunction

  state_t              state_q, state_d;
  logic [MAX_LEN-1:0]  pattern_q, pattern_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [MAX_LEN-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]    fill_q, fill_d;
  logic                z_q, z_d;
  logic                cfg_err_q, cfg_err_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                sat_q, sat_d;
  logic [7*DIGITS-1:0] disp_q, disp_d;

  logic [MAX_LEN-1:0]  mask_s;
  logic [MAX_LEN-1:0]  hist_sh_s;
  logic [LEN_W-1:0]    fill_inc_s;
  logic                len_ok_s;
  logic                match_s;

  // Compare mask covering the low len_q bits of history and pattern.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
  end

  // Candidate history/fill after accepting the current sample, and match test on it.
  always_comb begin
    hist_sh_s  = {hist_q[MAX_LEN-2:0], bus.sig_to_test};
    fill_inc_s = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : (fill_q + LEN_W'(1));
    len_ok_s   = (bus.cfg_len != LEN_W'(0)) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    match_s    = (fill_inc_s >= len_q) && (((hist_sh_s ^ pattern_q) & mask_s) == '0);
  end

  // Next-state logic: loads, sampling FSM, match pulse, counter and display.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    z_d       = 1'b0;
    cfg_err_d = 1'b0;
    count_d   = count_q;
    sat_d     = sat_q;
    disp_d    = disp_of(count_q);

    if (bus.cfg_valid && len_ok_s) begin
      // A fresh load wins over the sample taken in the same cycle.
      pattern_d = bus.cfg_pattern;
      len_d     = bus.cfg_len;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = ST_FILL;
    end else begin
      // A rejected load only flags the error; sampling carries on.
      cfg_err_d = bus.cfg_valid;
      case (state_q)
        ST_CFG: begin
          state_d = ST_CFG;
        end
        ST_FILL, ST_RUN: begin
          if (bus.ena) begin
            hist_d = hist_sh_s;
            fill_d = fill_inc_s;
            if (match_s && (OVERLAP == 0)) begin
              z_d     = 1'b1;
              fill_d  = '0;
              state_d = ST_FILL;
            end else if (match_s) begin
              z_d     = 1'b1;
              state_d = ST_RUN;
            end else if (fill_inc_s >= len_q) begin
              state_d = ST_RUN;
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_CFG;
        end
      endcase
    end

    // Count advances during the z cycle; a clear in that cycle wins.
    if (bus.clr_count) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (z_q && all_nines(count_q)) begin
      sat_d = 1'b1;
    end else if (z_q) begin
      count_d = bcd_inc(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CFG;
      pattern_q <= '0;
      len_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
      cfg_err_q <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      disp_q    <= disp_of('0);
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      z_q       <= z_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      disp_q    <= disp_d;
    end
  end

  assign bus.z         = z_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.count_bcd = count_q;
  assign bus.sat       = sat_q;
  assign bus.disp      = disp_q;
endmodule

// File: tb/tb_pattern_detector_counter.sv
// Bench: two detectors (overlapping/active-low and non-overlapping/active-high)
// driven by the same stimulus and compared every cycle to a queue-based model.
module tb_pattern_detector_counter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic       t_ena, t_sig, t_cfgv, t_clr;
  logic [7:0] t_pat;
  logic [3:0] t_len;

  pattern_detector_counter_if #(.MAX_LEN(8), .DIGITS(2)) bus_ov ();
  pattern_detector_counter_if #(.MAX_LEN(8), .DIGITS(2)) bus_no ();

  assign bus_ov.ena = t_ena;   assign bus_no.ena = t_ena;
  assign bus_ov.sig_to_test = t_sig;   assign bus_no.sig_to_test = t_sig;
  assign bus_ov.cfg_valid = t_cfgv;    assign bus_no.cfg_valid = t_cfgv;
  assign bus_ov.cfg_pattern = t_pat;   assign bus_no.cfg_pattern = t_pat;
  assign bus_ov.cfg_len = t_len;       assign bus_no.cfg_len = t_len;
  assign bus_ov.clr_count = t_clr;     assign bus_no.clr_count = t_clr;

  pattern_detector_counter #(.MAX_LEN(8), .DIGITS(2), .OVERLAP(1), .SEG_ACTIVE_LOW(1)) dut_ov (
    .clk(clk), .rst(rst), .bus(bus_ov));
  pattern_detector_counter #(.MAX_LEN(8), .DIGITS(2), .OVERLAP(0), .SEG_ACTIVE_LOW(0)) dut_no (
    .clk(clk), .rst(rst), .bus(bus_no));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] GLYPH [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  // Reference model, index 0 = overlapping/active-low, 1 = non-overlapping/active-high.
  bit         m_loaded [2];
  logic [7:0] m_pat    [2];
  int         m_len    [2];
  bit         m_z      [2];
  bit         m_err    [2];
  int         m_count  [2];
  bit         m_sat    [2];
  logic [13:0] m_disp  [2];
  bit         mq [2][$];

  function automatic logic [13:0] exp_disp(input int c, input int m);
    logic [6:0] g0, g1;
    g0 = GLYPH[c % 10];
    g1 = GLYPH[(c / 10) % 10];
    if (m == 1) begin g0 = ~g0; g1 = ~g1; end
    return {g1, g0};
  endfunction

  function automatic logic [7:0] to_bcd(input int c);
    logic [3:0] lo, hi;
    lo = 4'(c % 10);
    hi = 4'((c / 10) % 10);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_loaded[m] = 1'b0; m_pat[m] = '0; m_len[m] = 0; m_z[m] = 1'b0; m_err[m] = 1'b0;
      m_count[m] = 0; m_sat[m] = 1'b0; m_disp[m] = exp_disp(0, m);
      mq[m].delete();
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic [13:0] nd;
        int nc;
        bit ns, ne, nz, ok;
        nd = exp_disp(m_count[m], m);
        nc = m_count[m];
        ns = m_sat[m];
        if (t_clr) begin nc = 0; ns = 1'b0; end
        else if (m_z[m]) begin
          if (nc == 99) ns = 1'b1; else nc = nc + 1;
        end
        ne = t_cfgv && ((t_len == 4'd0) || (t_len > 4'd8));
        nz = 1'b0;
        if (t_cfgv && !ne) begin
          m_loaded[m] = 1'b1; m_pat[m] = t_pat; m_len[m] = int'(t_len);
          mq[m].delete();
        end else if (m_loaded[m] && t_ena) begin
          mq[m].push_back(t_sig);
          if (mq[m].size() >= m_len[m]) begin
            ok = 1'b1;
            for (int k = 0; k < m_len[m]; k++)
              if (mq[m][mq[m].size() - 1 - k] != m_pat[m][k]) ok = 1'b0;
            if (ok) begin
              nz = 1'b1;
              if (m == 1) mq[m].delete();
            end
          end
          if (mq[m].size() > 20) void'(mq[m].pop_front());
        end
        m_disp[m] = nd; m_count[m] = nc; m_sat[m] = ns; m_err[m] = ne; m_z[m] = nz;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ov_z",     32'(bus_ov.z),         32'(m_z[0]));
    chk("ov_err",   32'(bus_ov.cfg_err),   32'(m_err[0]));
    chk("ov_count", 32'(bus_ov.count_bcd), 32'(to_bcd(m_count[0])));
    chk("ov_sat",   32'(bus_ov.sat),       32'(m_sat[0]));
    chk("ov_disp",  32'(bus_ov.disp),      32'(m_disp[0]));
    chk("no_z",     32'(bus_no.z),         32'(m_z[1]));
    chk("no_err",   32'(bus_no.cfg_err),   32'(m_err[1]));
    chk("no_count", 32'(bus_no.count_bcd), 32'(to_bcd(m_count[1])));
    chk("no_sat",   32'(bus_no.sat),       32'(m_sat[1]));
    chk("no_disp",  32'(bus_no.disp),      32'(m_disp[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic ena, input logic sig, input logic cfgv,
                       input logic [7:0] pat, input logic [3:0] len, input logic clr);
    t_ena = ena; t_sig = sig; t_cfgv = cfgv; t_pat = pat; t_len = len; t_clr = clr;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len);
    drive(1'b0, 1'b0, 1'b1, pat, len, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic feed(input logic b);
    drive(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0);
    step();
  endtask

  logic [5:0] seq6;
  int         r;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    model_reset();
    step(); step();
    chk("rst_count", 32'(bus_ov.count_bcd), 32'h0);
    chk("rst_disp_ov", 32'(bus_ov.disp), 32'({7'b1000000, 7'b1000000}));
    chk("rst_disp_no", 32'(bus_no.disp), 32'({7'b0111111, 7'b0111111}));
    rst = 1'b0;

    // Pattern 0101 len 4, stream 0,1,0,1,0,1
    load(8'b0000_0101, 4'd4);
    seq6 = 6'b010101;
    for (int i = 5; i >= 0; i--) begin
      feed(seq6[i]);
      if (i == 2) begin
        chk("p0101_ov_z4", 32'(bus_ov.z), 32'd1);
        chk("p0101_no_z4", 32'(bus_no.z), 32'd1);
      end
    end
    chk("p0101_ov_z6", 32'(bus_ov.z), 32'd1);
    chk("p0101_no_z6", 32'(bus_no.z), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    step();
    chk("p0101_ov_cnt", 32'(bus_ov.count_bcd), 32'h02);
    chk("p0101_no_cnt", 32'(bus_no.count_bcd), 32'h01);
    step();
    chk("p0101_ov_disp", 32'(bus_ov.disp), 32'({7'b1000000, 7'b0100100}));
    chk("p0101_no_disp", 32'(bus_no.disp), 32'({7'b0111111, 7'b0000110}));

    // Pattern 011 len 3 with ena gaps between bits
    load(8'b0000_0011, 4'd3);
    feed(1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0); step();
    feed(1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0); step();
    chk("gap_z_early", 32'(bus_ov.z), 32'd0);
    feed(1'b1);
    chk("gap_ov_z", 32'(bus_ov.z), 32'd1);
    chk("gap_no_z", 32'(bus_no.z), 32'd1);

    // Rejected loads in RUN leave detection of 110 running
    load(8'b0000_0110, 4'd3);
    feed(1'b1); feed(1'b1); feed(1'b0);
    chk("bad0_pre_z", 32'(bus_ov.z), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 4'd0, 1'b0); step();
    chk("bad0_err", 32'(bus_ov.cfg_err), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 4'd9, 1'b0); step();
    chk("bad9_err", 32'(bus_no.cfg_err), 32'd1);
    feed(1'b1);
    chk("bad_err_clear", 32'(bus_ov.cfg_err), 32'd0);
    feed(1'b1); feed(1'b0);
    chk("bad_ov_z", 32'(bus_ov.z), 32'd1);
    chk("bad_no_z", 32'(bus_no.z), 32'd1);

    // Saturation: len-1 pattern "1" matches every accepted 1
    load(8'b0000_0001, 4'd1);
    for (int i = 0; i < 103; i++) feed(1'b1);
    chk("sat_cnt", 32'(bus_ov.count_bcd), 32'h99);
    chk("sat_flag", 32'(bus_ov.sat), 32'd1);
    chk("sat_no_flag", 32'(bus_no.sat), 32'd1);
    chk("sat_z_on", 32'(bus_ov.z), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1); step();
    chk("clr_cnt", 32'(bus_ov.count_bcd), 32'h00);
    chk("clr_sat", 32'(bus_ov.sat), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0); step(); step();

    // Asynchronous reset while z is high
    load(8'b0000_0101, 4'd4);
    feed(1'b0); feed(1'b1); feed(1'b0); feed(1'b1);
    chk("arst_pre_z", 32'(bus_ov.z), 32'd1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_z", 32'(bus_ov.z), 32'd0);
    chk("arst_cnt", 32'(bus_ov.count_bcd), 32'h00);
    chk("arst_disp", 32'(bus_ov.disp), 32'({7'b1000000, 7'b1000000}));
    check_all();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) feed(i[0]);
    chk("arst_no_z", 32'(bus_ov.z), 32'd0);

    // Randomized traffic
    drive(1'b0, 1'b0, 1'b1, 8'($urandom), 4'($urandom_range(1, 4)), 1'b0); step();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      t_cfgv = 1'b0; t_pat = 8'($urandom); t_len = 4'd0;
      if (r < 2) begin
        t_cfgv = 1'b1; t_len = 4'($urandom_range(1, 4));
      end else if (r < 3) begin
        t_cfgv = 1'b1;
        t_len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      end
      t_ena = ($urandom_range(0, 3) != 0);
      t_sig = 1'($urandom_range(0, 1));
      t_clr = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pattern_detector_counter.md
PATTERN_DETECTOR_COUNTER -- requirements
Module: pattern_detector_counter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MAX_LEN, 8, maximum pattern length in bits (legal 2..16).
- DIGITS, 2, number of BCD count digits and 7-segment displays (legal 1..4).
- OVERLAP, 1, 1 = overlapping matches counted, 0 = non-overlapping.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low, 0 = active-high.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- ena, in, 1, sample enable for sig_to_test.
- sig_to_test, in, 1, serial input bit under test.
- cfg_valid, in, 1, pattern load request.
- cfg_pattern, in, MAX_LEN, pattern; bit cfg_len-1 = first bit received, bit 0 = last.
- cfg_len, in, clog2(MAX_LEN+1), pattern length.
- cfg_err, out, 1, one-cycle pulse when a load is rejected.
- clr_count, in, 1, synchronous clear of count and sat.
- z, out, 1, one-cycle detection pulse.
- count_bcd, out, 4*DIGITS, BCD count; digit 0 in bits [3:0].
- sat, out, 1, sticky counter-saturated flag.
- disp, out, 7*DIGITS, segments gfedcba per digit; digit 0 in bits [6:0].

Function
REQ-003 FSM states SHALL be CFG, FILL and RUN; reset enters CFG.
REQ-004 In CFG, z SHALL stay 0 and samples SHALL be ignored.
REQ-005 A load SHALL occur in any state when cfg_valid=1 and 1<=cfg_len<=MAX_LEN: latch pattern and length, clear history and fill count, enter FILL next cycle.
REQ-006 When cfg_valid=1 with cfg_len=0 or cfg_len>MAX_LEN, the block SHALL pulse cfg_err for 1 cycle and leave state, pattern and history unchanged.
REQ-007 On each cycle with ena=1, the history SHALL shift left with sig_to_test entering bit 0; the fill count SHALL increment and saturate at MAX_LEN. With ena=0, history and fill SHALL hold.
REQ-008 FILL SHALL move to RUN when fill >= length.
REQ-009 A match SHALL be the registered ena sample where fill (including that sample) >= length and history[length-1:0] == pattern[length-1:0].
REQ-010 z SHALL be 1 for exactly the cycle after the matching sample; latency is 1 clock.
REQ-011 If OVERLAP=0, a match SHALL reset fill to 0 and return the FSM to FILL. If OVERLAP=1, fill SHALL be unaffected.
REQ-012 The count SHALL be DIGITS-digit BCD and increment by 1 in the cycle z=1, carrying decimally.
REQ-013 At all-9s, a further z SHALL hold the count and set sat to 1. sat SHALL remain 1 until clr_count or rst.
REQ-014 When clr_count=1, count and sat SHALL be 0 next cycle; clr_count SHALL take priority over a simultaneous z increment.
REQ-015 A load SHALL NOT clear count or sat.
REQ-016 disp SHALL be registered from count_bcd, one clock behind it.
REQ-017 Active-low glyph codes 0-9 SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000. If SEG_ACTIVE_LOW=0, these codes SHALL be bitwise inverted.

Reset
REQ-018 While rst=1 the block SHALL, asynchronously, set state to CFG, pattern, length, history and fill to 0, z, cfg_err and sat to 0, and count_bcd to 0; every disp digit SHALL show the glyph "0".
REQ-019 Assertion of rst mid-match or mid-load SHALL discard all partial state; no z pulse SHALL follow reset release.

Verification
REQ-020 Load pattern 0b0101 with len 4, OVERLAP=1, then feed 0,1,0,1,0,1 with ena=1 -> z pulses after the 4th and 6th bits; count_bcd = 0x02; disp digit 0 = 0100100.
REQ-021 Same stimulus with OVERLAP=0 -> a single z pulse after the 4th bit; count_bcd = 0x01.
REQ-022 DIGITS=2, count preset to 99 via 99 matches, then one more match -> count_bcd stays 0x99 and sat = 1. Then clr_count coinciding with a z pulse -> count_bcd = 0x00 and sat = 0.
REQ-023 cfg_valid with cfg_len=0 while in RUN -> cfg_err pulses for 1 cycle; detection of the old pattern continues uninterrupted.
REQ-024 ena toggled low between pattern bits 0,1,1 (len 3) -> match is still detected and z fires 1 cycle after the last enabled sample.
REQ-025 rst asserted asynchronously between clock edges mid-sequence -> all outputs reach reset values before the next edge; FSM = CFG and z never asserts until a new load and fill.
